// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request types: packets, fill data and the restart FIFO entry
// layout used by the request arbiter.
package l2_request_arbiter_pkg;

   localparam int NUM_CORES       = 4;
   localparam int CACHE_LINE_BITS = 64;

   typedef enum logic [2:0] {
      L2REQ_LOAD,
      L2REQ_STORE,
      L2REQ_LOAD_SYNC,
      L2REQ_STORE_SYNC,
      L2REQ_FLUSH,
      L2REQ_IINVALIDATE,
      L2REQ_DINVALIDATE
   } l2req_packet_type_t;

   typedef struct packed {
      l2req_packet_type_t packet_type;
      logic [3:0]         id;
      logic [25:0]        address;
   } l2req_packet_t;

   typedef logic [CACHE_LINE_BITS-1:0] cache_line_data_t;

   typedef struct packed {
      l2req_packet_t    packet;
      cache_line_data_t data;
      logic             collided;
   } restart_fifo_entry_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int REQUESTER_ID_WIDTH = id_width(NUM_CORES);
   typedef logic [REQUESTER_ID_WIDTH-1:0] requester_id_t;

endpackage

// File: rtl/l2_request_arbiter_fifo.sv
// Synchronous FIFO holding restarted requests; full/empty come straight
// from the registered occupancy count.
module l2_request_arbiter_fifo #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(SIZE);

   logic [WIDTH-1:0] mem [SIZE];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;

   assign full     = (count == (AW+1)'(SIZE));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// Head of the L2 pipeline: issues restarted requests ahead of new core
// requests, with a burst limit so waiting cores are not starved.
module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS     = NUM_CORES,
   parameter int RESTART_FIFO_DEPTH = 4,
   parameter int MAX_RESTART_BURST  = 8
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_REQUESTERS-1:0]               l2i_request_valid,
   input  l2req_packet_t [NUM_REQUESTERS-1:0]      l2i_request,
   output logic [NUM_REQUESTERS-1:0]               l2_ready,
   input  logic                                    l2bi_request_valid,
   input  l2req_packet_t                           l2bi_request,
   input  cache_line_data_t                        l2bi_data_from_memory,
   input  logic                                    l2bi_collided_miss,
   output logic                                    l2bi_restart_ready,
   input  logic                                    l2bi_stall,
   output logic                                    l2a_request_valid,
   output l2req_packet_t                           l2a_request,
   output cache_line_data_t                        l2a_data_from_memory,
   output logic                                    l2a_l2_fill,
   output logic                                    l2a_restarted_flush,
   output logic [id_width(NUM_REQUESTERS)-1:0]     l2a_requester_id
);

   localparam int ID_W    = id_width(NUM_REQUESTERS);
   localparam int BURST_W = (MAX_RESTART_BURST > 0) ? $clog2(MAX_RESTART_BURST + 1) : 1;
   localparam int ENTRY_W = $bits(restart_fifo_entry_t);

   restart_fifo_entry_t        push_entry;
   restart_fifo_entry_t        head;
   logic [ENTRY_W-1:0]         head_bits;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       force_core;
   logic                       issue_restart;
   logic                       can_accept_core;
   logic                       core_issue;
   logic [NUM_REQUESTERS-1:0]  grant_oh;
   logic [ID_W-1:0]            grant_idx;
   logic [BURST_W-1:0]         burst_cnt;

   assign push_entry         = '{packet: l2bi_request, data: l2bi_data_from_memory,
                                 collided: l2bi_collided_miss};
   assign l2bi_restart_ready = !fifo_full;
   assign push               = l2bi_request_valid && !fifo_full;
   assign head               = head_bits;

   l2_request_arbiter_fifo #(
      .WIDTH (ENTRY_W),
      .SIZE  (RESTART_FIFO_DEPTH)
   ) restart_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (issue_restart),
      .pop_data  (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   generate
      if (MAX_RESTART_BURST == 0) begin : g_no_guard
         assign force_core = 1'b0;
      end else begin : g_guard
         assign force_core = (burst_cnt == BURST_W'(MAX_RESTART_BURST)) && (|l2i_request_valid);
      end
   endgenerate

   assign issue_restart   = !l2bi_stall && !fifo_empty && !force_core;
   assign can_accept_core = !l2bi_stall && (fifo_empty || force_core);
   assign core_issue      = can_accept_core && (|l2i_request_valid);
   assign l2_ready        = can_accept_core ? grant_oh : '0;

   generate
      if (NUM_REQUESTERS == 1) begin : g_single
         assign grant_oh  = l2i_request_valid;
         assign grant_idx = '0;
      end else begin : g_rr
         logic [ID_W-1:0] rr_ptr;
         logic [ID_W-1:0] cand;
         int              j;

         // Walk offsets from farthest to nearest so the requester closest
         // to rr_ptr is the last to overwrite the grant.
         always_comb begin
            grant_oh  = '0;
            grant_idx = '0;
            cand      = '0;
            j         = 0;
            for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
               j = int'(rr_ptr) + k;
               if (j >= NUM_REQUESTERS)
                  j = j - NUM_REQUESTERS;
               cand = ID_W'(j);
               if (l2i_request_valid[cand]) begin
                  grant_oh       = '0;
                  grant_oh[cand] = 1'b1;
                  grant_idx      = cand;
               end
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               rr_ptr <= '0;
            else if (core_issue)
               rr_ptr <= (grant_idx == ID_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         burst_cnt <= '0;
      else if (fifo_empty || core_issue)
         burst_cnt <= '0;
      else if (issue_restart && (MAX_RESTART_BURST != 0)
               && (burst_cnt != BURST_W'(MAX_RESTART_BURST)))
         burst_cnt <= burst_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l2a_request_valid    <= 1'b0;
         l2a_request          <= '0;
         l2a_data_from_memory <= '0;
         l2a_l2_fill          <= 1'b0;
         l2a_restarted_flush  <= 1'b0;
         l2a_requester_id     <= '0;
      end else begin
         l2a_request_valid <= issue_restart || core_issue;
         if (issue_restart) begin
            l2a_request          <= head.packet;
            l2a_data_from_memory <= head.data;
            l2a_l2_fill          <= !head.collided && (head.packet.packet_type != L2REQ_FLUSH);
            l2a_restarted_flush  <= (head.packet.packet_type == L2REQ_FLUSH);
            l2a_requester_id     <= '0;
         end else if (core_issue) begin
            l2a_request          <= l2i_request[grant_idx];
            l2a_data_from_memory <= '0;
            l2a_l2_fill          <= 1'b0;
            l2a_restarted_flush  <= 1'b0;
            l2a_requester_id     <= grant_idx;
         end
      end
   end

   // The bus interface only restarts fills and flushes, never invalidates.
   restart_push_type_legal: assert property (@(posedge clk) disable iff (!reset)
      push |-> !(l2bi_request.packet_type inside {L2REQ_IINVALIDATE, L2REQ_DINVALIDATE}));

endmodule
